// File: rtl/mon_commit_serializer_pkg.sv
// Shared types for the retire-monitor commit serializer: packet layout, error codes, halt states.
package mon_pkg;

    typedef struct packed {
        logic [31:0] order;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        halt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  frd;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        mem_we;
        logic        mem_re;
    } mon_pkt_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_GAP       = 3'd1,
        ERR_ORDER     = 3'd2,
        ERR_OVF       = 3'd3,
        ERR_POST_HALT = 3'd4,
        ERR_TIMEOUT   = 3'd5
    } mon_err_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALTING  = 2'd1,
        ST_HALTED   = 2'd2
    } mon_halt_state_e;

endpackage

// File: rtl/mon_commit_serializer_if.sv
// Retire-side (multi-lane) and comparator-side (single valid/ready) bundle of the serializer.
interface mon_commit_serializer_if #(
    parameter int CHANNELS = 2
);
    import mon_pkg::*;

    logic [CHANNELS-1:0]  in_valid;
    mon_pkt_t [CHANNELS-1:0] in_pkt;
    logic                 out_valid;
    mon_pkt_t             out_pkt;
    logic                 out_ready;

    modport master (
        output in_valid, in_pkt, out_ready,
        input  out_valid, out_pkt
    );

    modport slave (
        input  in_valid, in_pkt, out_ready,
        output out_valid, out_pkt
    );

endinterface

// File: rtl/mon_pkt_fifo.sv
// Circular packet buffer: up to WR_LANES writes per cycle in lane order, one read per cycle.
module mon_pkt_fifo
    import mon_pkg::*;
#(
    parameter int  WR_LANES = 2,
    parameter int  DEPTH    = 16,
    localparam int AW       = $clog2(DEPTH),
    localparam int PW       = AW + 1,
    localparam int CW       = $clog2(WR_LANES + 1)
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [CW-1:0]            wr_count,
    input  mon_pkt_t [WR_LANES-1:0]  wr_data,
    input  logic                     rd_en,
    output mon_pkt_t                 rd_data,
    output logic                     empty,
    output logic [PW-1:0]            occupancy
);

    mon_pkt_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [AW-1:0] lane_addr [WR_LANES];

    // Address wrap comes for free from the AW-bit truncation.
    genvar gi;
    generate
        for (gi = 0; gi < WR_LANES; gi++) begin : g_lane_addr
            assign lane_addr[gi] = wr_ptr_reg[AW-1:0] + AW'(gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_LANES; i++) begin
            if (CW'(i) < wr_count) begin
                mem[lane_addr[i]] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PW'(wr_count);
            if (rd_en && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    assign occupancy = wr_ptr_reg - rd_ptr_reg;
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    // Head is read combinationally so an entry written at t is visible at t+1;
    // an empty buffer presents zeros so stale entries never leak out.
    assign rd_data   = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/mon_commit_serializer.sv
// Multi-lane retire monitor: checks prefix/order/halt rules, buffers packets, drains one per cycle.
// Optional idle watchdog enabled by defining MON_COMMIT_TIMEOUT_EN.
module mon_commit_serializer
    import mon_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    parameter int TIMEOUT  = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    mon_commit_serializer_if.slave   bus,
    output logic                     halted,
    output logic                     error,
    output logic [2:0]               err_code,
    output logic [63:0]              commit_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CHANNELS + 1);

    generate
        if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
            $error("mon_commit_serializer: CHANNELS must be 1..8");
        end
        if (DEPTH < 2 * CHANNELS || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("mon_commit_serializer: DEPTH must be a power of two >= 2*CHANNELS");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("mon_commit_serializer: TIMEOUT must be positive");
        end
    endgenerate

    mon_halt_state_e state_reg;
    mon_err_e        err_code_reg;
    logic            error_reg;
    logic            halted_reg;
    logic [31:0]     exp_order_reg;
    logic [63:0]     commit_count_reg;

    logic            fifo_empty;
    logic [PW-1:0]   fifo_occ;
    mon_pkt_t        fifo_rd_data;

    int              lane_cnt;
    int              keep_cnt;
    int              accept_cnt;
    logic            gap;
    logic            order_bad;
    logic            halt_hit;
    logic            ovf;
    logic            halt_accept;
    logic            pop;
    logic            timeout_hit;
    mon_err_e        err_now;

    assign pop = bus.out_valid && bus.out_ready;

    always_comb begin
        lane_cnt    = 0;
        keep_cnt    = 0;
        accept_cnt  = 0;
        gap         = 1'b0;
        order_bad   = 1'b0;
        halt_hit    = 1'b0;
        ovf         = 1'b0;
        halt_accept = 1'b0;
        err_now     = ERR_NONE;

        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.in_valid[i]) lane_cnt = lane_cnt + 1;
        end
        for (int i = 1; i < CHANNELS; i++) begin
            if (bus.in_valid[i] && !bus.in_valid[i-1]) gap = 1'b1;
        end
        // Scan downward so the lowest-numbered halt lane ends up deciding keep_cnt.
        keep_cnt = lane_cnt;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.in_valid[i] && bus.in_pkt[i].halt) begin
                halt_hit = 1'b1;
                keep_cnt = i + 1;
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.in_valid[i] && (bus.in_pkt[i].order != exp_order_reg + 32'(i))) begin
                order_bad = 1'b1;
            end
        end
        // Capacity is judged against current occupancy; a same-cycle pop earns no credit.
        ovf = (int'(fifo_occ) + lane_cnt) > DEPTH;

        if (gap) begin
            err_now = ERR_GAP;
        end else if (state_reg != ST_RUN) begin
            if (lane_cnt != 0) err_now = ERR_POST_HALT;
        end else if (ovf) begin
            err_now = ERR_OVF;
        end else begin
            accept_cnt  = keep_cnt;
            halt_accept = halt_hit;
            if (order_bad) begin
                err_now = ERR_ORDER;
            end else if (keep_cnt < lane_cnt) begin
                err_now = ERR_POST_HALT;
            end
        end
        if (err_now == ERR_NONE && timeout_hit) begin
            err_now = ERR_TIMEOUT;
        end
    end

`ifdef MON_COMMIT_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_reg;

    assign timeout_hit = (state_reg == ST_RUN) && !(|bus.in_valid)
                         && (idle_reg == IW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_reg <= '0;
        end else if (|bus.in_valid) begin
            idle_reg <= '0;
        end else if (state_reg == ST_RUN && idle_reg != IW'(TIMEOUT)) begin
            idle_reg <= idle_reg + IW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_RUN;
            err_code_reg     <= ERR_NONE;
            error_reg        <= 1'b0;
            halted_reg       <= 1'b0;
            exp_order_reg    <= '0;
            commit_count_reg <= '0;
        end else begin
            // Overflow drops still advance the order so one lost group is one error, not many.
            if (!gap) begin
                exp_order_reg <= exp_order_reg + 32'(lane_cnt);
            end
            commit_count_reg <= commit_count_reg + 64'(accept_cnt);
            if (!error_reg && err_now != ERR_NONE) begin
                error_reg    <= 1'b1;
                err_code_reg <= err_now;
            end
            case (state_reg)
                ST_RUN: begin
                    if (halt_accept) state_reg <= ST_HALTING;
                end
                ST_HALTING: begin
                    if (pop && bus.out_pkt.halt) begin
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_reg <= ST_HALTED;
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    mon_pkt_fifo #(
        .WR_LANES (CHANNELS),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .wr_count  (CW'(accept_cnt)),
        .wr_data   (bus.in_pkt),
        .rd_en     (bus.out_ready),
        .rd_data   (fifo_rd_data),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_pkt   = fifo_rd_data;
    assign halted        = halted_reg;
    assign error         = error_reg;
    assign err_code      = err_code_reg;
    assign commit_count  = commit_count_reg;

endmodule

// File: doc/mon_commit_serializer.md
Name: mon_commit_serializer

Overview:
- Bench-side successor to the multi-channel monitor interface.
- Each cycle it accepts up to CHANNELS retire packets and checks lane prefix, order contiguity and halt discipline.
- Accepted packets are buffered and drained one per cycle, in order, over a valid/ready port to the single-channel reference-model comparator.
- Errors are sticky and reported with the first failing cause.

Parameters:
CHANNELS, 2, number of retire lanes sampled per cycle (1..8)
DEPTH, 16, buffer entries; power of two, >= 2*CHANNELS
TIMEOUT, 100000, idle-cycle limit; used only with MON_COMMIT_TIMEOUT_EN

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  CHANNELS  per-lane retire valid
in_pkt  input  CHANNELS x mon_pkt_t  per-lane packet: order, inst, halt, rs1/rs2/rd/frd, pc, mem fields
out_valid  output  1  buffered packet available
out_pkt  output  mon_pkt_t  head packet
out_ready  input  1  comparator consumes head
halted  output  1  halt packet has drained
error  output  1  sticky error flag
err_code  output  3  first error cause
commit_count  output  64  packets accepted since reset

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - all outputs 0, out_pkt 0
  - buffer empty, expected_order = 0
  - halt FSM in RUN
- Input check order, applied each cycle:
  - Prefix rule: lane i valid requires lane i-1 valid. Violation -> ERR_GAP (1); whole group dropped.
  - Order rule: valid lane i needs in_pkt[i].order == expected_order + i. Mismatch -> ERR_ORDER (2); group still accepted.
  - Capacity rule: k = count of valid lanes. If occupancy + k > DEPTH, with a same-cycle pop not credited -> ERR_OVF (3); group dropped.
- Counter updates:
  - expected_order advances by k on every non-gap cycle, including overflow drops, to avoid cascaded order errors.
  - commit_count advances by accepted entries only.
- Buffer:
  - Circular buffer; lanes are written in lane order at wr_ptr..wr_ptr+k-1, modulo DEPTH.
  - Pointers are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
- Output:
  - out_valid = !empty; out_pkt = mem[rd_ptr].
  - A packet accepted in cycle t is first visible in t+1.
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle: occupancy_next = occupancy + k_accepted - pop.
- Halt FSM (RUN, HALTING, HALTED):
  - RUN -> HALTING when an accepted lane has halt = 1.
  - Lanes after the halt lane in the same group are dropped with ERR_POST_HALT (4).
  - HALTING -> HALTED on the cycle the halt packet pops; halted = 1 from the next cycle.
  - Any valid input in HALTING or HALTED -> ERR_POST_HALT; packet dropped.
  - HALTED persists until reset.
- Error reporting:
  - error and err_code latch on the first error only.
  - Errors in later cycles leave err_code unchanged.
  - Same-cycle priority: GAP > OVF > ORDER > POST_HALT.
- Reset asserted mid-stream flushes the buffer and FSM with no residual output the next cycle.

Optional Feature:
MON_COMMIT_TIMEOUT_EN
- Defined:
  - Idle counter clears on any in_valid and in reset.
  - While FSM is RUN it increments each cycle with no valid lane.
  - Reaching TIMEOUT raises ERR_TIMEOUT (5) under the normal sticky/first-error rules; the counter saturates.
- Undefined: no counter is synthesised and code 5 never occurs.

Decomposition:
- Package mon_pkg holds:
  - mon_pkt_t, a packed struct of the per-channel monitor fields
  - mon_err_e: NONE=0, GAP=1, ORDER=2, OVF=3, POST_HALT=4, TIMEOUT=5
  - mon_halt_state_e
- Sub-module mon_pkt_fifo: parametrised multi-write (up to CHANNELS), single-read circular buffer with occupancy output.
- Checking and halt FSM stay in the top module.

Test Plan:
- CHANNELS=2, lanes {1,1} with orders 0,1, then {1,0} with order 2, out_ready=1 -> out_pkt orders 0,1,2 on consecutive cycles from t+1; commit_count=3; error=0.
- in_valid={lane1=1, lane0=0} -> error=1, err_code=1, nothing buffered, expected_order stays 0.
- Orders 0,1 then 3,4 -> err_code=2; all four packets delivered; a later gap does not change err_code.
- DEPTH=4, out_ready=0, four groups of 2 -> first two accepted; third group raises err_code=3 and is dropped; occupancy=4.
- Lane0 halt=1 with lane1 valid -> lane1 dropped, err_code=4; halted rises the cycle after the halt packet pops; further valids keep halted=1.
- MON_COMMIT_TIMEOUT_EN, TIMEOUT=8, no valids after reset -> err_code=5 after exactly 8 idle cycles; macro undefined -> error stays 0.
